// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Purpose  : Sequencing controller for a direct-mapped cache data/tag array.
//            Accepts one CPU load or store at a time. It performs a tag
//            compare against the array. On a miss it writes back a dirty
//            victim line and refills the line from a pipelined main memory.
//            It then repeats the compare to complete the access.
// Ports    :
//   clk, rst_n           clock, asynchronous active-low reset
//   cpu_rd / cpu_wr      load / store request (sampled in IDLE only)
//   cpu_addr, cpu_wdata  byte address {tag, index[7:0], offset[3:0]}, data
//   cpu_rdata            load data, valid with cpu_done
//   cpu_done             one-cycle completion pulse
//   cpu_stall            controller busy
//   cpu_hit, cpu_err     with cpu_done: hit on first compare / bad request
//   c_*  (out)           cache array enable/comp/write/valid_in/tag/index/
//                        offset/data_in
//   c_*  (in)            cache array tag_out/data_out/hit/dirty/valid
//   mem_wr, mem_rd       memory request strobes (never both)
//   mem_addr, mem_wdata  word-aligned address and write data
//   mem_rdata            read data, MEM_LAT cycles after an accepted read
//   mem_stall            memory did not accept this cycle's request
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int  TAG_WIDTH = 4,
    parameter int  MEM_LAT   = 2,
    localparam int AW        = TAG_WIDTH + 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // CPU side
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [AW-1:0]        cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_done,
    output logic                 cpu_stall,
    output logic                 cpu_hit,
    output logic                 cpu_err,
    // Cache array side
    output logic                 c_enable,
    output logic                 c_comp,
    output logic                 c_write,
    output logic                 c_valid_in,
    output logic [TAG_WIDTH-1:0] c_tag,
    output logic [7:0]           c_index,
    output logic [3:0]           c_offset,
    output logic [31:0]          c_wdata,
    input  logic [TAG_WIDTH-1:0] c_tag_out,
    input  logic [31:0]          c_rdata,
    input  logic                 c_hit,
    input  logic                 c_dirty,
    input  logic                 c_valid,
    // Main memory side
    output logic                 mem_wr,
    output logic                 mem_rd,
    output logic [AW-1:0]        mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_stall
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMP   = 3'd1,
        ST_WB    = 3'd2,
        ST_FILL  = 3'd3,
        ST_RETRY = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    // Latched request
    logic [AW-1:0]          r_addr;
    logic [31:0]            r_wdata;
    logic                   r_op;          // 1 = store
    logic [TAG_WIDTH-1:0]   r_victim;

    // r_req_k: word index of the next memory request. In FILL bit 2 set means
    // all four reads were accepted and we are only waiting for returns.
    logic [2:0]             r_req_k;
    logic [1:0]             r_ret_k;       // number of fill words written

    // Read-return tracker: one stage per cycle of memory latency.
    logic [MEM_LAT-1:0]     r_pipe_v;
    logic [1:0]             r_pipe_k [MEM_LAT];

    logic [TAG_WIDTH-1:0]   w_tag;
    logic [7:0]             w_index;
    logic                   w_req_any;
    logic                   w_req_bad;
    logic                   w_rd_accept;
    logic                   w_wb_accept;
    logic                   w_ret_valid;
    logic [1:0]             w_ret_k;
    logic                   w_lookup_hit;
    logic                   w_victim_dirty;

    assign w_tag          = r_addr[AW-1:12];
    assign w_index        = r_addr[11:4];
    assign w_req_any      = cpu_rd | cpu_wr;
    assign w_req_bad      = (cpu_rd & cpu_wr) | (w_req_any & (cpu_addr[1:0] != 2'b00));
    assign w_rd_accept    = (r_state == ST_FILL) & ~r_req_k[2] & ~mem_stall;
    assign w_wb_accept    = (r_state == ST_WB) & ~mem_stall;
    // Returns are only meaningful while filling; the tracker is empty elsewhere.
    assign w_ret_valid    = (r_state == ST_FILL) & r_pipe_v[MEM_LAT-1];
    assign w_ret_k        = r_pipe_k[MEM_LAT-1];
    assign w_lookup_hit   = c_hit & c_valid;
    assign w_victim_dirty = ~w_lookup_hit & c_valid & c_dirty;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_op     <= 1'b0;
            r_victim <= '0;
            r_req_k  <= '0;
            r_ret_k  <= '0;
            r_pipe_v <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_pipe_k[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;

            if ((r_state == ST_IDLE) && w_req_any && !w_req_bad) begin
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
                r_op    <= cpu_wr;
                r_req_k <= '0;
                r_ret_k <= '0;
            end

            if ((r_state == ST_CMP) && w_victim_dirty) begin
                r_victim <= c_tag_out;
            end

            // The write-back counter wraps to 0 so the fill starts at word 0.
            if (w_wb_accept) begin
                r_req_k <= (r_req_k[1:0] == 2'd3) ? 3'd0 : (r_req_k + 3'd1);
            end else if (w_rd_accept) begin
                r_req_k <= r_req_k + 3'd1;
            end

            if (w_ret_valid) begin
                r_ret_k <= r_ret_k + 2'd1;
            end

            r_pipe_v[0] <= w_rd_accept;
            r_pipe_k[0] <= r_req_k[1:0];
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_k[i] <= r_pipe_k[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        cpu_rdata    = '0;
        cpu_done     = 1'b0;
        cpu_hit      = 1'b0;
        cpu_err      = 1'b0;
        c_enable     = 1'b0;
        c_comp       = 1'b0;
        c_write      = 1'b0;
        c_valid_in   = 1'b0;
        c_tag        = '0;
        c_index      = '0;
        c_offset     = '0;
        c_wdata      = '0;
        mem_wr       = 1'b0;
        mem_rd       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        // The first compare and the post-fill retry drive the array the same
        // way. In RETRY a store lands in the freshly filled line and marks
        // it dirty.
        if ((r_state == ST_CMP) || (r_state == ST_RETRY)) begin
            c_enable = 1'b1;
            c_comp   = 1'b1;
            c_write  = r_op;
            c_tag    = w_tag;
            c_index  = w_index;
            c_offset = r_addr[3:0];
            c_wdata  = r_wdata;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_req_any) begin
                    w_next_state = w_req_bad ? ST_ERR : ST_CMP;
                end
            end

            ST_ERR: begin
                cpu_done     = 1'b1;
                cpu_err      = 1'b1;
                w_next_state = ST_IDLE;
            end

            ST_CMP: begin
                if (w_lookup_hit) begin
                    cpu_done     = 1'b1;
                    cpu_hit      = 1'b1;
                    cpu_rdata    = r_op ? 32'h0 : c_rdata;
                    w_next_state = ST_IDLE;
                end else if (w_victim_dirty) begin
                    w_next_state = ST_WB;
                end else begin
                    w_next_state = ST_FILL;
                end
            end

            ST_WB: begin
                // Read victim word k from the array and forward it to memory
                // in the same cycle. Hold both until memory accepts.
                c_enable  = 1'b1;
                c_tag     = r_victim;
                c_index   = w_index;
                c_offset  = {r_req_k[1:0], 2'b00};
                mem_wr    = 1'b1;
                mem_addr  = {r_victim, w_index, r_req_k[1:0], 2'b00};
                mem_wdata = c_rdata;
                if (w_wb_accept && (r_req_k[1:0] == 2'd3)) begin
                    w_next_state = ST_FILL;
                end
            end

            ST_FILL: begin
                // Memory requests do not touch the cache port, so a read
                // request and a return write can share a cycle.
                if (!r_req_k[2]) begin
                    mem_rd   = 1'b1;
                    mem_addr = {w_tag, w_index, r_req_k[1:0], 2'b00};
                end
                if (w_ret_valid) begin
                    c_enable   = 1'b1;
                    c_write    = 1'b1;
                    c_valid_in = 1'b1;
                    c_tag      = w_tag;
                    c_index    = w_index;
                    c_offset   = {w_ret_k, 2'b00};
                    c_wdata    = mem_rdata;
                    if (r_ret_k == 2'd3) begin
                        w_next_state = ST_RETRY;
                    end
                end
            end

            ST_RETRY: begin
                cpu_done     = 1'b1;
                cpu_rdata    = r_op ? 32'h0 : c_rdata;
                w_next_state = ST_IDLE;
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        cpu_stall = (r_state != ST_IDLE) & ~cpu_done;
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_cache_ctrl
// Purpose  : Self-checking bench for dm_cache_ctrl. It models the
//            direct-mapped cache array and a pipelined memory with a
//            two-cycle read latency. Expected completions and memory
//            requests are queued when a request is issued. They are popped
//            and compared when the controller produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_cache_ctrl;

    localparam int TW  = 4;
    localparam int LAT = 2;
    localparam int AW  = TW + 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cpu_rd, cpu_wr;
    logic [AW-1:0]   cpu_addr;
    logic [31:0]     cpu_wdata, cpu_rdata;
    logic            cpu_done, cpu_stall, cpu_hit, cpu_err;
    logic            c_enable, c_comp, c_write, c_valid_in;
    logic [TW-1:0]   c_tag, c_tag_out;
    logic [7:0]      c_index;
    logic [3:0]      c_offset;
    logic [31:0]     c_wdata, c_rdata;
    logic            c_hit, c_dirty, c_valid;
    logic            mem_wr, mem_rd;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata = 32'h0;
    logic            mem_stall;

    always #5 clk = ~clk;

    dm_cache_ctrl #(.TAG_WIDTH(TW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
        .cpu_hit(cpu_hit), .cpu_err(cpu_err),
        .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write), .c_valid_in(c_valid_in),
        .c_tag(c_tag), .c_index(c_index), .c_offset(c_offset), .c_wdata(c_wdata),
        .c_tag_out(c_tag_out), .c_rdata(c_rdata),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall)
    );

    // ---------------- cache array model ----------------
    bit [TW-1:0] ct   [256];
    bit          cv   [256];
    bit          cd   [256];
    bit [31:0]   cdat [256][4];

    assign c_tag_out = ct[c_index];
    assign c_valid   = cv[c_index];
    assign c_dirty   = cd[c_index];
    assign c_rdata   = cdat[c_index][c_offset[3:2]];
    assign c_hit     = c_enable & c_comp & (ct[c_index] == c_tag);

    always @(posedge clk) begin
        if (c_enable && c_write) begin
            if (c_comp) begin
                if (cv[c_index] && (ct[c_index] == c_tag)) begin
                    cdat[c_index][c_offset[3:2]] <= c_wdata;
                    cd[c_index]                  <= 1'b1;
                end
            end else begin
                cdat[c_index][c_offset[3:2]] <= c_wdata;
                ct[c_index]                  <= c_tag;
                cv[c_index]                  <= c_valid_in;
                cd[c_index]                  <= 1'b0;
            end
        end
    end

    // ---------------- main memory model ----------------
    function automatic logic [31:0] iw(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    logic [31:0] mem   [16384];
    bit          wrote [16384];
    logic        rv0 = 1'b0;
    logic [15:0] ra0 = 16'h0;

    function automatic logic [31:0] mem_read(input logic [15:0] a);
        return wrote[a[15:2]] ? mem[a[15:2]] : iw({a[15:2], 2'b00});
    endfunction

    always @(posedge clk) begin
        rv0       <= mem_rd & ~mem_stall;
        ra0       <= mem_addr;
        mem_rdata <= rv0 ? mem_read(ra0) : 32'h0;
        if (mem_wr && !mem_stall) begin
            mem[mem_addr[15:2]]   <= mem_wdata;
            wrote[mem_addr[15:2]] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        hit;
        logic        err;
        int          done_cyc;
    } cpu_exp_t;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    cpu_exp_t cpu_q [$];
    mem_exp_t mem_q [$];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    cpu_exp_t    me;
    mem_exp_t    mm;
    logic        hold_prev = 1'b0;
    logic [1:0]  hold_op;
    logic [15:0] hold_addr;
    logic [31:0] hold_data;

    always @(negedge clk) begin
        #1;
        cyc++;
        if (cpu_done) begin
            chk("done_expected", 64'(cpu_q.size() != 0), 64'd1);
            if (cpu_q.size() != 0) begin
                me = cpu_q.pop_front();
                chk("cpu_rdata", 64'(cpu_rdata), 64'(me.rdata));
                chk("cpu_hit",   64'(cpu_hit),   64'(me.hit));
                chk("cpu_err",   64'(cpu_err),   64'(me.err));
                chk("done_cycle", 64'(cyc),      64'(me.done_cyc));
            end
        end
        if (hold_prev) begin
            chk("stall_hold_op",   64'({mem_rd, mem_wr}), 64'(hold_op));
            chk("stall_hold_addr", 64'(mem_addr),         64'(hold_addr));
            if (hold_op[0]) chk("stall_hold_wdata", 64'(mem_wdata), 64'(hold_data));
        end
        if ((mem_rd || mem_wr) && !mem_stall) begin
            chk("mem_rd_wr_excl", 64'(mem_rd & mem_wr), 64'd0);
            chk("mem_expected", 64'(mem_q.size() != 0), 64'd1);
            if (mem_q.size() != 0) begin
                mm = mem_q.pop_front();
                chk("mem_is_wr", 64'(mem_wr),   64'(mm.wr));
                chk("mem_addr",  64'(mem_addr), 64'(mm.addr));
                if (mm.wr) chk("mem_wdata", 64'(mem_wdata), 64'(mm.wdata));
            end
        end
        hold_prev = (mem_rd | mem_wr) & mem_stall;
        hold_op   = {mem_rd, mem_wr};
        hold_addr = mem_addr;
        hold_data = mem_wdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic exp_line(input logic wr, input logic [15:0] base, input int nwords,
                            input int ovr_k, input logic [31:0] ovr_d);
        mem_exp_t m;
        for (int k = 0; k < nwords; k++) begin
            m.wr    = wr;
            m.addr  = base + 16'(k * 4);
            m.wdata = (k == ovr_k) ? ovr_d : iw(m.addr);
            mem_q.push_back(m);
        end
    endtask

    // lat = 0 issues the request without expecting a completion.
    task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [31:0] xr,
                         input logic xh, input logic xe, input int lat);
        cpu_exp_t e;
        @(negedge clk);
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        if (lat > 0) begin
            e.rdata    = xr;
            e.hit      = xh;
            e.err      = xe;
            e.done_cyc = cyc + 1 + lat;
            cpu_q.push_back(e);
        end
        @(negedge clk);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (((cpu_q.size() + mem_q.size()) != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(cpu_q.size() + mem_q.size()), 64'd0);
        cpu_q.delete();
        mem_q.delete();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_stall = 1'b0;
        rst_n     = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_ctl", 64'({cpu_done, cpu_stall, cpu_hit, cpu_err, c_enable, c_comp,
                            c_write, c_valid_in, mem_wr, mem_rd}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Clean miss then hit on the same line.
        exp_line(1'b0, 16'h0120, 4, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h0120, 32'h0, iw(16'h0120), 1'b0, 1'b0, 8);
        drain("clean_miss_drain", 40);
        issue(1'b1, 1'b0, 16'h0120, 32'h0, iw(16'h0120), 1'b1, 1'b0, 1);
        drain("load_hit_drain", 40);

        // Store hit makes the line dirty, then a conflicting load evicts it.
        issue(1'b0, 1'b1, 16'h0124, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 1);
        drain("store_hit_drain", 40);
        exp_line(1'b1, 16'h0120, 4, 1, 32'hDEADBEEF);
        exp_line(1'b0, 16'h1120, 4, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h1124, 32'h0, iw(16'h1124), 1'b0, 1'b0, 12);
        drain("dirty_miss_drain", 40);

        // Illegal requests: misaligned, and simultaneous load+store.
        issue(1'b1, 1'b0, 16'h0122, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        #1;
        chk("err_misalign_quiet", 64'({c_enable, mem_rd, mem_wr, cpu_stall}), 64'd0);
        drain("err_misalign_drain", 40);
        issue(1'b1, 1'b1, 16'h0200, 32'h5555AAAA, 32'h0, 1'b0, 1'b1, 1);
        #1;
        chk("err_rdwr_quiet", 64'({c_enable, mem_rd, mem_wr, cpu_stall}), 64'd0);
        drain("err_rdwr_drain", 40);

        // Three stall cycles while FILL word 1 is requested.
        exp_line(1'b0, 16'h3450, 4, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h3458, 32'h0, iw(16'h3458), 1'b0, 1'b0, 11);
        repeat (2) @(negedge clk);
        mem_stall = 1'b1;
        #1;
        chk("busy_stall", 64'(cpu_stall), 64'd1);
        repeat (3) @(negedge clk);
        mem_stall = 1'b0;
        drain("fill_stall_drain", 40);

        // Store miss: completes after refill and the data must read back.
        exp_line(1'b0, 16'h4560, 4, -1, 32'h0);
        issue(1'b0, 1'b1, 16'h4568, 32'h12345678, 32'h0, 1'b0, 1'b0, 8);
        drain("store_miss_drain", 40);
        issue(1'b1, 1'b0, 16'h4568, 32'h0, 32'h12345678, 1'b1, 1'b0, 1);
        drain("store_readback_drain", 40);

        // Dirty eviction of that line with two stall cycles on write-back word 0.
        exp_line(1'b1, 16'h4560, 4, 2, 32'h12345678);
        exp_line(1'b0, 16'h5560, 4, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h5568, 32'h0, iw(16'h5568), 1'b0, 1'b0, 14);
        @(negedge clk);
        mem_stall = 1'b1;
        repeat (2) @(negedge clk);
        mem_stall = 1'b0;
        drain("wb_stall_drain", 40);

        // Reset during FILL word 2, then a fresh miss must complete cleanly.
        exp_line(1'b0, 16'h2340, 2, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h2340, 32'h0, 32'h0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_quiet", 64'({cpu_stall, mem_rd, mem_wr, c_enable, cpu_done}), 64'd0);
        #2;
        rst_n = 1'b1;
        drain("pre_reset_drain", 1);
        exp_line(1'b0, 16'h0120, 4, -1, 32'h0);
        issue(1'b1, 1'b0, 16'h0120, 32'h0, iw(16'h0120), 1'b0, 1'b0, 8);
        drain("post_reset_drain", 40);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
